memory_arbiter: RTL
===================

Name: memory_arbiter

Overview:
- Shares the single-ported unified RAM between the instruction-fetch path (imemREN side) and the data path (dREN/dWEN side) of the pipelined core.
- Sits between the datapath/caches and the RAM model.
- Sequences one RAM transaction at a time, holds the losing requester with a wait signal, and gives data priority with bounded instruction starvation.
- Detects a stuck RAM through a timeout.

Parameters:
- MAX_DSTREAK, 4: consecutive data grants allowed while an instruction request is pending before the instruction request is forced next.
- TIMEOUT, 64: cycles a granted transaction may wait for ram_ack before it is aborted.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- halt  in  1  core halted; no new instruction grants
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  data write value
- ramload  in  32  RAM read data
- ram_ack  in  1  RAM transaction complete (single-cycle pulse)
- iwait  out  1  instruction requester must hold
- dwait  out  1  data requester must hold
- iload  out  32  instruction read data
- dload  out  32  data read data
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- bus_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (synchronous, CLK edge with RST=1):
  - state=IDLE, dstreak=0, tcount=0.
  - ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0, bus_err=0.
  - iwait=iREN and dwait=dREN|dWEN (combinational).
  - Reset mid-transaction abandons it; no ack is honoured after reset.
- FSM states: IDLE, DGRANT, IGRANT.
- IDLE arbitration, registered (the grant takes effect the next cycle):
  - (dREN|dWEN) and not force_i -> DGRANT.
  - Else iREN and not halt -> IGRANT.
  - Else stay in IDLE.
  - force_i = (dstreak==MAX_DSTREAK) and iREN and not halt.
- DGRANT outputs (combinational from state):
  - ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN and not dWEN. Write wins if both are set.
  - dwait=1 until the ram_ack cycle. In that cycle dwait=0 and dload=ramload.
  - Next state IDLE.
- IGRANT outputs: same pattern with iaddr, ramREN=1, iwait/iload.
- Minimum latency: a request seen in IDLE at cycle t is granted at t+1. With ack at t+1, wait drops at t+1 and the requester is free at t+2.
- Back-to-back requests: each transaction spends one IDLE cycle between grants; no grant chaining.
- The non-granted requester always sees wait=1 while its request is high.
- Request dropped while granted (enable falls before ack):
  - Strobes deassert that cycle and the state returns to IDLE.
  - A later stray ram_ack in IDLE is ignored.
- dstreak:
  - Increments (saturating at MAX_DSTREAK) on each completed DGRANT while iREN=1.
  - Clears on completed IGRANT or any cycle with iREN=0.
- tcount:
  - Counts cycles in a grant state and clears on entering IDLE.
  - At tcount==TIMEOUT-1 without ack: bus_err=1 for one cycle, the granted wait drops, load data=32'hBAD0BAD0, and the state goes to IDLE.
- halt=1 does not stop an in-flight IGRANT; data grants are still served.
- ram_ack in the same cycle as timeout: ack wins and bus_err stays 0.

Decomposition:
- cpu_types_pkg gains arbstate_t {IDLE, DGRANT, IGRANT} and the constant BUS_ERR_WORD=32'hBAD0BAD0. word_t is used for all 32-bit ports.
- A memory_arbiter_if interface provides modports arb and tb.
- One natural sub-module: arb_watchdog, holding the tcount counter, compare logic and bus_err pulse, with clear/enable inputs.

Test Plan:
- Reset mid-DGRANT → next cycle state IDLE, ramWEN=0, dstreak=0; a stale ack is ignored.
- Simultaneous iREN=1 and dREN=1 (daddr=0x40) with ack after 2 cycles → DGRANT first, ramaddr=0x40, dwait low in the ack cycle; IGRANT follows after one IDLE cycle.
- Continuous dREN and iREN, MAX_DSTREAK=4, ack every grant → grant order D,D,D,D,I,D,D,D,D,I; iwait is never high longer than 4 data transactions.
- dREN=dWEN=1, dstore=0xDEADBEEF → ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
- iREN with no ack, TIMEOUT=64 → bus_err pulse at grant cycle+63, iload=0xBAD0BAD0, iwait low for exactly that cycle; ack in that same cycle instead → bus_err=0, iload=ramload.
- halt=1 with iREN=1 and dREN=0 → no IGRANT, ramREN=0 indefinitely; raising dREN → DGRANT served normally.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter and its neighbours.
//   word_t       : 32-bit bus word used by every address/data port
//   arbstate_t   : arbiter FSM states
//   BUS_ERR_WORD : load value returned when a transaction is aborted by timeout
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arbstate_t;

    localparam word_t BUS_ERR_WORD = 32'hBAD0BAD0;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of every memory_arbiter signal.
//   arb : arbiter view (requests/RAM responses in, waits/loads/RAM strobes out)
//   tb  : requester + RAM-model view (mirror of arb)
interface memory_arbiter_if
    import cpu_types_pkg::*;
(
    input logic CLK
);

    logic  RST;
    logic  halt;
    logic  iREN;
    logic  dREN;
    logic  dWEN;
    logic  ram_ack;
    logic  iwait;
    logic  dwait;
    logic  ramREN;
    logic  ramWEN;
    logic  bus_err;
    word_t iaddr;
    word_t daddr;
    word_t dstore;
    word_t ramload;
    word_t iload;
    word_t dload;
    word_t ramaddr;
    word_t ramstore;

    modport arb (
        input  CLK, RST, halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ack,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, bus_err
    );

    modport tb (
        input  CLK, iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, bus_err,
        output RST, halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ack
    );

endinterface

// File: rtl/arb_watchdog.sv
// Grant watchdog: counts cycles spent in a grant state and flags a stuck RAM.
//   CLK, RST : clock, synchronous active-high reset
//   clear    : zero the counter (arbiter is idle)
//   enable   : a grant is in progress, count this cycle
//   ack      : RAM acknowledged this cycle (beats the timeout)
//   bus_err  : combinational pulse in the cycle the grant is aborted
module arb_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    input  logic ack,
    output logic bus_err
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] tcount;

    // Holds at LAST so the counter can never wrap back to an innocent value.
    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            tcount <= '0;
        end else if (enable && tcount != LAST) begin
            tcount <= tcount + 1'b1;
        end
    end

    assign bus_err = enable && (tcount == LAST) && !ack;

endmodule

// File: rtl/memory_arbiter.sv
// Arbiter sharing one single-ported RAM between instruction fetch and data
// access. Data has priority; after MAX_DSTREAK data grants with a pending
// fetch the fetch is forced. One transaction at a time, one idle cycle
// between grants, and a watchdog aborts grants that never see ram_ack.
//   CLK, RST              : clock, synchronous active-high reset
//   halt                  : blocks new instruction grants
//   iREN, iaddr           : instruction read request
//   dREN, dWEN, daddr,
//   dstore                : data read/write request
//   ramload, ram_ack      : RAM response
//   iwait/iload,
//   dwait/dload           : requester hold and returned data
//   ramREN, ramWEN,
//   ramaddr, ramstore     : RAM command
//   bus_err               : one-cycle pulse on timeout abort
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned MAX_DSTREAK = 4,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  halt,
    input  logic  iREN,
    input  word_t iaddr,
    input  logic  dREN,
    input  logic  dWEN,
    input  word_t daddr,
    input  word_t dstore,
    input  word_t ramload,
    input  logic  ram_ack,
    output logic  iwait,
    output logic  dwait,
    output word_t iload,
    output word_t dload,
    output logic  ramREN,
    output logic  ramWEN,
    output word_t ramaddr,
    output word_t ramstore,
    output logic  bus_err
);

    localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

    arbstate_t     state;
    arbstate_t     next_state;
    logic [SW-1:0] dstreak;
    logic          dreq;
    logic          force_i;
    logic          granted;
    logic          done;
    logic          expired;

    assign dreq    = dREN | dWEN;
    assign force_i = (dstreak == STREAK_MAX) && iREN && !halt;
    assign granted = (state != IDLE);
    assign done    = granted && (ram_ack || expired);
    assign bus_err = expired;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .CLK     (CLK),
        .RST     (RST),
        .clear   (!granted),
        .enable  (granted),
        .ack     (ram_ack),
        .bus_err (expired)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Streak only matters while a fetch is actually waiting.
    always_ff @(posedge CLK) begin
        if (RST || !iREN) begin
            dstreak <= '0;
        end else if (state == IGRANT && done) begin
            dstreak <= '0;
        end else if (state == DGRANT && done && dstreak != STREAK_MAX) begin
            dstreak <= dstreak + 1'b1;
        end
    end

    // Every grant returns to IDLE, so each transaction costs an idle cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (dreq && !force_i) begin
                    next_state = DGRANT;
                end else if (iREN && !halt) begin
                    next_state = IGRANT;
                end
            end
            DGRANT: if (!dreq || ram_ack || expired) next_state = IDLE;
            IGRANT: if (!iREN || ram_ack || expired) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        iwait    = iREN;
        dwait    = dreq;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN && !dWEN;
                if (ram_ack) begin
                    dwait = 1'b0;
                    dload = ramload;
                end else if (expired) begin
                    dwait = 1'b0;
                    dload = BUS_ERR_WORD;
                end
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (ram_ack) begin
                    iwait = 1'b0;
                    iload = ramload;
                end else if (expired) begin
                    iwait = 1'b0;
                    iload = BUS_ERR_WORD;
                end
            end
            default: ;
        endcase
    end

endmodule
